// File: rtl/noc_iq_pkg.sv
// Shared definitions for the router input-queue slice: FSM states, default
// geometry constants and the VC index width derivation.
package noc_iq_pkg;

    localparam int unsigned NOC_FW = 64;
    localparam int unsigned NOC_P  = 7;
    localparam int unsigned NOC_V  = 2;
    localparam int unsigned NOC_B  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } iq_state_e;

    function automatic int unsigned vc_idx_width(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC circular FIFO with a combinational head read; the caller qualifies
// push so that a push into a full FIFO only happens alongside a pop.
module vc_fifo #(
    parameter int unsigned DATA_WIDTH = 71,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  not_empty,
    output logic                  full
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries no reset so it can map onto RAM; occupancy lives in count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign head      = mem_q[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign full      = (count_q == (ADDR_WIDTH + 1)'(DEPTH));

endmodule

// File: rtl/input_queue_vc.sv
// Multi-VC router input port: per-VC flit FIFOs, round-robin head selection and
// multicast service with partial grants, returning one VC-tagged credit per pop.
module input_queue_vc
    import noc_iq_pkg::*;
#(
    parameter int unsigned FW = NOC_FW,
    parameter int unsigned P  = NOC_P,
    parameter int unsigned V  = NOC_V,
    parameter int unsigned B  = NOC_B,
    parameter int unsigned VW = vc_idx_width(V)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flit_in_wr,
    input  logic [VW-1:0] flit_in_vc,
    input  logic [FW-1:0] flit_in,
    input  logic [P-1:0]  dest_in,
    output logic [FW-1:0] flit_to_crossbar,
    output logic [VW-1:0] vc_to_crossbar,
    output logic [P-1:0]  dest_port_req,
    input  logic [P-1:0]  grant_dest_port,
    output logic          flit_rel,
    output logic [VW-1:0] flit_rel_vc,
    output logic [V-1:0]  vc_not_empty,
    output logic          overflow_err
);

    localparam int unsigned DW = FW + P;

    logic [V-1:0]  push;
    logic [V-1:0]  pop;
    logic [V-1:0]  full;
    logic [DW-1:0] head [V];

    iq_state_e     state_q, state_d;
    logic [VW-1:0] active_vc_q, active_vc_d;
    logic [VW-1:0] rr_q, rr_d;
    logic [P-1:0]  pending_q, pending_d;
    logic [FW-1:0] flit_hold_q, flit_hold_d;
    logic [VW-1:0] vc_hold_q, vc_hold_d;
    logic          overflow_q;

    logic          complete;
    logic          wr_drop;
    logic [P-1:0]  remaining;
    logic [DW-1:0] active_head;
    logic [VW-1:0] cand;
    logic          found;

    for (genvar g = 0; g < V; g++) begin : g_vc
        vc_fifo #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (B)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[g]),
            .pop       (pop[g]),
            .din       ({flit_in, dest_in}),
            .head      (head[g]),
            .not_empty (vc_not_empty[g]),
            .full      (full[g])
        );
    end

    // A full VC still accepts a write in the cycle it pops; out-of-range VCs match nothing.
    always_comb begin
        push = '0;
        for (int unsigned v = 0; v < V; v++) begin
            if (flit_in_wr && (flit_in_vc == VW'(v)) && (!full[v] || pop[v])) begin
                push[v] = 1'b1;
            end
        end
    end

    assign wr_drop     = flit_in_wr && (push == '0);
    assign active_head = head[active_vc_q];
    assign remaining   = pending_q & ~grant_dest_port;

    always_comb begin
        state_d     = state_q;
        active_vc_d = active_vc_q;
        rr_d        = rr_q;
        pending_d   = pending_q;
        flit_hold_d = flit_hold_q;
        vc_hold_d   = vc_hold_q;
        pop         = '0;
        complete    = 1'b0;
        found       = 1'b0;
        cand        = '0;
        case (state_q)
            IDLE: begin
                for (int unsigned i = 1; i <= V; i++) begin
                    cand = VW'((32'(rr_q) + i) % V);
                    if (!found && vc_not_empty[cand]) begin
                        found       = 1'b1;
                        active_vc_d = cand;
                        pending_d   = head[cand][P-1:0];
                        state_d     = SERVE;
                    end
                end
            end
            SERVE: begin
                flit_hold_d = active_head[DW-1:P];
                vc_hold_d   = active_vc_q;
                pending_d   = remaining;
                if (remaining == '0) begin
                    complete         = 1'b1;
                    pop[active_vc_q] = 1'b1;
                    rr_d             = active_vc_q;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            active_vc_q <= '0;
            rr_q        <= VW'(V - 1);
            pending_q   <= '0;
            flit_hold_q <= '0;
            vc_hold_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_vc_q <= active_vc_d;
            rr_q        <= rr_d;
            pending_q   <= pending_d;
            flit_hold_q <= flit_hold_d;
            vc_hold_q   <= vc_hold_d;
            overflow_q  <= overflow_q | wr_drop;
        end
    end

    assign dest_port_req    = (state_q == SERVE) ? pending_q : '0;
    assign flit_to_crossbar = (state_q == SERVE) ? active_head[DW-1:P] : flit_hold_q;
    assign vc_to_crossbar   = (state_q == SERVE) ? active_vc_q : vc_hold_q;
    assign flit_rel         = complete;
    assign flit_rel_vc      = active_vc_q;
    assign overflow_err     = overflow_q;

endmodule

// File: doc/input_queue_vc.md
# input_queue_vc

Multi-virtual-channel router input port. Buffers incoming flits and their precomputed destination-port masks in V per-VC FIFOs and selects one VC head at a time, round-robin. Presents that head to the switch allocator/crossbar as a multicast request and tracks partial grants until every destination port has been served. Pops the flit and returns one credit tagged with its VC. Sits between the link receiver and the crossbar in each router port; V=1 gives a single-channel input port with overflow checking.

## Interface
- FW, 64: flit width in bits.
- P, 7: router port count; width of destination masks.
- V, 2: number of virtual channels, ≥1.
- B, 2: log2 of per-VC FIFO depth (D = 2^B).
- VW, max(1, clog2(V)): VC index width (derived).

- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flit_in_wr  in  1  write strobe for flit_in/dest_in/flit_in_vc.
- flit_in_vc  in  VW  target VC of the write.
- flit_in  in  FW  incoming flit.
- dest_in  in  P  destination-port mask from route computation.
- flit_to_crossbar  out  FW  head flit of the VC being served.
- vc_to_crossbar  out  VW  VC being served.
- dest_port_req  out  P  outstanding output-port requests.
- grant_dest_port  in  P  output ports granted to this input this cycle.
- flit_rel  out  1  one-cycle credit pulse on pop.
- flit_rel_vc  out  VW  VC of the credit.
- vc_not_empty  out  V  per-VC occupancy flag.
- overflow_err  out  1  sticky: a write hit a full VC.

## Operation
- Write: when flit_in_wr=1, push {flit_in, dest_in} into the VC selected by flit_in_vc.
  - The write is accepted if that VC holds fewer than D entries, or if it pops in the same cycle.
  - Otherwise the write is dropped and overflow_err is set. overflow_err clears only on reset.
  - flit_in_vc ≥ V: write dropped, overflow_err set.
- FSM states:
  - IDLE: if any vc_not_empty, pick the first non-empty VC after rr_ptr (wrapping), set active_vc, load pending from that head's mask, go to SERVE. Otherwise stay in IDLE.
  - SERVE:
    - dest_port_req = pending.
    - flit_to_crossbar = head of active_vc.
    - vc_to_crossbar = active_vc.
    - Update: pending ← pending & ~grant_dest_port. Grant bits outside pending are ignored.
    - Completion: when (pending & ~grant_dest_port) == 0, that same cycle pop active_vc, pulse flit_rel with flit_rel_vc = active_vc, set rr_ptr ← active_vc, go to IDLE.
- Head mask loaded as 0: SERVE completes in its first cycle. The flit is discarded and the credit is still returned.
- Outside SERVE: dest_port_req = 0; flit_to_crossbar and vc_to_crossbar hold their last values.
- Per-VC FIFO behaviour:
  - Pointers wrap modulo D.
  - Count is B+1 bits.
  - Simultaneous push and pop on the same VC leaves the count unchanged.
  - The head is read combinationally from storage.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - all FIFOs empty; FSM in IDLE; rr_ptr = V-1, so VC0 wins first;
  - pending = 0; dest_port_req = 0; flit_to_crossbar = 0; vc_to_crossbar = 0;
  - flit_rel = 0; flit_rel_vc = 0; vc_not_empty = 0; overflow_err = 0.
- Reset mid-SERVE discards all buffered flits. No credits are returned; the upstream side is reset together with this block.
- A write in cycle t gives vc_not_empty=1 from t+1. IDLE selects at t+1, and dest_port_req is asserted at t+2.
- A full grant in the first SERVE cycle gives flit_rel in that same cycle (t+2).
- Each flit costs at least one IDLE cycle plus one SERVE cycle, so peak throughput is 1 flit per 2 cycles.
- flit_rel is exactly one cycle per popped flit. No two pops occur in one cycle.

## Structure
- Shared package noc_iq_pkg holds:
  - the state enum {IDLE, SERVE};
  - the VW derivation function;
  - the default FW/P/V/B constants shared with the router top.
- Sub-module vc_fifo (DATA_WIDTH=FW+P, ADDR_WIDTH=B), instantiated V times in a generate loop. Ports: push, pop, din, head, not_empty, full.
- The top level contains the round-robin selector, the FSM, the pending register and overflow logic.

## Test plan
- Unicast, V=2: write VC1 flit 0xA5 with mask 0000100; grant 0000100 at first SERVE cycle. Expect req at t+2, flit_rel=1 with flit_rel_vc=1 in that cycle, vc_not_empty=00 after.
- Multicast partial grants: mask 0010110; grant 0000010, then 0010000, then 0000100. Expect pending progression 0010110 → 0010100 → 0000100 → 0, with a single flit_rel on the third grant only.
- Round-robin fairness: fill VC0 and VC1 with 4 flits each; grant all requests immediately. Expect served order VC0, VC1, VC0, VC1, … and 8 credits total.
- Overflow: 5 writes to VC0 (D=4) with no grants. Expect overflow_err=1 after the 5th write, and exactly 4 flits served in order once grants resume.
- Zero mask: write a flit with dest_in=0. Expect dest_port_req to stay 0 and flit_rel to pulse at t+2.
- Reset mid-SERVE: after a partial grant, drive rst_n=0 for one edge. Expect all outputs 0, FIFOs empty, and VC0 served first afterwards.
